// File: rtl/term_cursor_if.sv
// Key-event and character-RAM write bundle for the terminal cursor controller.
// Ports (slave side = controller):
//   key_valid/key_ascii  in   keyboard event strobe and code
//   key_ready            out  controller can take an event this cycle
//   wr_en/wr_addr/wr_data out character RAM write port
//   cursor_addr          out  physical address of the cursor cell
//   top_row              out  physical row shown on the top screen line
//   busy                 out  controller is initialising or clearing a row
interface term_cursor_if;
  logic        key_valid;
  logic [7:0]  key_ascii;
  logic        key_ready;
  logic        wr_en;
  logic [11:0] wr_addr;
  logic [7:0]  wr_data;
  logic [11:0] cursor_addr;
  logic [4:0]  top_row;
  logic        busy;

  modport master (
    output key_valid, key_ascii,
    input  key_ready, wr_en, wr_addr, wr_data, cursor_addr, top_row, busy
  );

  modport slave (
    input  key_valid, key_ascii,
    output key_ready, wr_en, wr_addr, wr_data, cursor_addr, top_row, busy
  );
endinterface

// File: rtl/term_cursor_ctrl.sv
// Write-side controller for the VGA text terminal character RAM.
// Owns the cursor, places characters, handles backspace/enter/wrap, scrolls by
// rotating top_row and clearing the recycled row, and clears the screen after reset.
// Ports:
//   clk    in  system clock
//   reset  in  synchronous active-high reset
//   tc     term_cursor_if.slave (key handshake in, RAM writes / cursor / top_row out)
module term_cursor_ctrl #(
  parameter int unsigned COLS = 70,
  parameter int unsigned ROWS = 30
) (
  input  logic         clk,
  input  logic         reset,
  term_cursor_if.slave tc
);
  localparam int unsigned ADDR_W = 12;
  localparam int unsigned ROW_W  = 5;
  localparam int unsigned COL_W  = 7;
  localparam int unsigned LU_W   = $clog2(ROWS + 1);
  localparam int unsigned CNT_W  = 13;
  localparam int unsigned CELLS  = COLS * ROWS;

  localparam logic [COL_W-1:0]  LAST_COL = COL_W'(COLS - 1);
  localparam logic [COL_W-1:0]  FULL_LEN = COL_W'(COLS);
  localparam logic [ROW_W-1:0]  LAST_ROW = ROW_W'(ROWS - 1);
  localparam logic [LU_W-1:0]   MAX_USED = LU_W'(ROWS);
  localparam logic [CNT_W-1:0]  INIT_END = CNT_W'(CELLS);
  localparam logic [CNT_W-1:0]  CLR_END  = CNT_W'(COLS);
  localparam logic [7:0]        SPACE    = 8'h20;

  typedef enum logic [1:0] {ST_INIT, ST_IDLE, ST_CLEAR} state_e;

  state_e             state_q, state_d;
  logic [ROW_W-1:0]   cur_row_q, cur_row_d;
  logic [COL_W-1:0]   cur_col_q, cur_col_d;
  logic [ROW_W-1:0]   top_row_q, top_row_d;
  logic [LU_W-1:0]    lines_used_q, lines_used_d;
  logic [COL_W-1:0]   line_len_q [ROWS];
  logic [COL_W-1:0]   line_len_d [ROWS];
  logic [CNT_W-1:0]   clr_cnt_q, clr_cnt_d;
  logic               wr_en_q, wr_en_d;
  logic [ADDR_W-1:0]  wr_addr_q, wr_addr_d;
  logic [7:0]         wr_data_q, wr_data_d;
  logic [ADDR_W-1:0]  cursor_addr_q, cursor_addr_d;

  logic               do_newline;
  logic               bs_write;
  logic [ROW_W-1:0]   nl_row;
  logic [ROW_W-1:0]   prev_row;
  logic [COL_W-1:0]   prev_len;

  function automatic logic [ADDR_W-1:0] cell_addr(input logic [ROW_W-1:0] r,
                                                  input logic [COL_W-1:0] c);
    return ADDR_W'(r) * ADDR_W'(COLS) + ADDR_W'(c);
  endfunction

  // State register
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= ST_INIT;
      cur_row_q     <= '0;
      cur_col_q     <= '0;
      top_row_q     <= '0;
      lines_used_q  <= LU_W'(1);
      line_len_q    <= '{default: '0};
      clr_cnt_q     <= '0;
      wr_en_q       <= 1'b0;
      wr_addr_q     <= '0;
      wr_data_q     <= SPACE;
      cursor_addr_q <= '0;
    end else begin
      state_q       <= state_d;
      cur_row_q     <= cur_row_d;
      cur_col_q     <= cur_col_d;
      top_row_q     <= top_row_d;
      lines_used_q  <= lines_used_d;
      line_len_q    <= line_len_d;
      clr_cnt_q     <= clr_cnt_d;
      wr_en_q       <= wr_en_d;
      wr_addr_q     <= wr_addr_d;
      wr_data_q     <= wr_data_d;
      cursor_addr_q <= cursor_addr_d;
    end
  end

  // Next-state: INIT/CLEAR sweep one cell per cycle, then spend one extra
  // cycle with no write before returning to IDLE.
  always_comb begin
    state_d      = state_q;
    cur_row_d    = cur_row_q;
    cur_col_d    = cur_col_q;
    top_row_d    = top_row_q;
    lines_used_d = lines_used_q;
    line_len_d   = line_len_q;
    clr_cnt_d    = clr_cnt_q;
    wr_en_d      = 1'b0;
    wr_addr_d    = wr_addr_q;
    wr_data_d    = wr_data_q;
    do_newline   = 1'b0;
    bs_write     = 1'b0;
    nl_row       = (cur_row_q == LAST_ROW) ? '0 : cur_row_q + ROW_W'(1);
    prev_row     = (cur_row_q == '0) ? LAST_ROW : cur_row_q - ROW_W'(1);
    prev_len     = line_len_q[prev_row];

    unique case (state_q)
      ST_INIT: begin
        if (clr_cnt_q < INIT_END) begin
          wr_en_d   = 1'b1;
          wr_addr_d = ADDR_W'(clr_cnt_q);
          wr_data_d = SPACE;
          clr_cnt_d = clr_cnt_q + CNT_W'(1);
        end else begin
          state_d   = ST_IDLE;
          clr_cnt_d = '0;
        end
      end

      ST_CLEAR: begin
        if (clr_cnt_q < CLR_END) begin
          wr_en_d   = 1'b1;
          wr_addr_d = cell_addr(cur_row_q, COL_W'(clr_cnt_q));
          wr_data_d = SPACE;
          clr_cnt_d = clr_cnt_q + CNT_W'(1);
        end else begin
          state_d   = ST_IDLE;
          clr_cnt_d = '0;
        end
      end

      ST_IDLE: begin
        if (tc.key_valid) begin
          if (tc.key_ascii >= 8'h20 && tc.key_ascii <= 8'h7E) begin
            wr_en_d   = 1'b1;
            wr_addr_d = cursor_addr_q;
            wr_data_d = tc.key_ascii;
            line_len_d[cur_row_q] = cur_col_q + COL_W'(1);
            if (cur_col_q < LAST_COL) cur_col_d = cur_col_q + COL_W'(1);
            else                      do_newline = 1'b1;
          end else if (tc.key_ascii == 8'h0D) begin
            line_len_d[cur_row_q] = cur_col_q;
            do_newline = 1'b1;
          end else if (tc.key_ascii == 8'h08) begin
            if (cur_col_q != '0) begin
              cur_col_d = cur_col_q - COL_W'(1);
              bs_write  = 1'b1;
            end else if (lines_used_q > LU_W'(1)) begin
              // Step back onto the previous line; a full line puts the cursor
              // on its last cell and erases it.
              cur_row_d    = prev_row;
              lines_used_d = lines_used_q - LU_W'(1);
              if (prev_len < FULL_LEN) begin
                cur_col_d = prev_len;
              end else begin
                cur_col_d = LAST_COL;
                bs_write  = 1'b1;
              end
            end
          end

          if (do_newline) begin
            cur_col_d          = '0;
            cur_row_d          = nl_row;
            line_len_d[nl_row] = '0;
            if (lines_used_q < MAX_USED) begin
              lines_used_d = lines_used_q + LU_W'(1);
            end else begin
              // Screen full: rotate the display and blank the recycled row.
              top_row_d = (top_row_q == LAST_ROW) ? '0 : top_row_q + ROW_W'(1);
              state_d   = ST_CLEAR;
              clr_cnt_d = '0;
            end
          end
        end
      end

      default: state_d = ST_INIT;
    endcase

    cursor_addr_d = cell_addr(cur_row_d, cur_col_d);

    // Backspace erases the cell the cursor lands on.
    if (bs_write) begin
      wr_en_d   = 1'b1;
      wr_addr_d = cursor_addr_d;
      wr_data_d = SPACE;
    end
  end

  assign tc.key_ready   = (state_q == ST_IDLE);
  assign tc.busy        = (state_q != ST_IDLE);
  assign tc.wr_en       = wr_en_q;
  assign tc.wr_addr     = wr_addr_q;
  assign tc.wr_data     = wr_data_q;
  assign tc.cursor_addr = cursor_addr_q;
  assign tc.top_row     = top_row_q;
endmodule

// File: tb/tb_term_cursor_ctrl.sv
// Self-checking bench for term_cursor_ctrl: directed vector table, hand-written
// timing sequences, and random key streams against a screen-level model.
module tb_term_cursor_ctrl;
  localparam int COLS  = 70;
  localparam int ROWS  = 30;
  localparam int CELLS = COLS * ROWS;

  logic clk = 1'b0;
  logic reset;

  term_cursor_if tc();

  term_cursor_ctrl #(.COLS(COLS), .ROWS(ROWS)) dut (
    .clk   (clk),
    .reset (reset),
    .tc    (tc)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Shadow of the character RAM built from observed writes
  logic [7:0] shadow [CELLS];
  always @(posedge clk) begin
    if (tc.wr_en === 1'b1 && int'(tc.wr_addr) < CELLS) shadow[tc.wr_addr] = tc.wr_data;
  end

  // Screen-level reference model
  int         m_row, m_col, m_used, m_top;
  int         m_len [ROWS];
  logic [7:0] m_ram [CELLS];

  function automatic void m_reset();
    m_row = 0; m_col = 0; m_used = 1; m_top = 0;
    for (int r = 0; r < ROWS; r++) m_len[r] = 0;
    for (int a = 0; a < CELLS; a++) m_ram[a] = 8'h20;
  endfunction

  function automatic void m_newline();
    m_col = 0;
    m_row = (m_row + 1) % ROWS;
    m_len[m_row] = 0;
    if (m_used < ROWS) m_used++;
    else begin
      m_top = (m_top + 1) % ROWS;
      for (int c = 0; c < COLS; c++) m_ram[m_row * COLS + c] = 8'h20;
    end
  endfunction

  function automatic void m_key(input logic [7:0] k);
    if (k >= 8'h20 && k <= 8'h7E) begin
      m_ram[m_row * COLS + m_col] = k;
      m_len[m_row] = m_col + 1;
      if (m_col < COLS - 1) m_col++;
      else m_newline();
    end else if (k == 8'h0D) begin
      m_len[m_row] = m_col;
      m_newline();
    end else if (k == 8'h08) begin
      if (m_col > 0) begin
        m_col--;
        m_ram[m_row * COLS + m_col] = 8'h20;
      end else if (m_used > 1) begin
        m_row = (m_row + ROWS - 1) % ROWS;
        m_used--;
        if (m_len[m_row] < COLS) m_col = m_len[m_row];
        else begin
          m_col = COLS - 1;
          m_ram[m_row * COLS + m_col] = 8'h20;
        end
      end
    end
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic check_ram(input string name);
    int bad = 0;
    for (int a = 0; a < CELLS; a++) if (shadow[a] !== m_ram[a]) bad++;
    check(name, bad, 0);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_ready(input int bound);
    int n = 0;
    while (tc.key_ready !== 1'b1 && n < bound) begin
      tick();
      n++;
    end
    if (tc.key_ready !== 1'b1) check("ready_timeout", tc.key_ready, 1);
  endtask

  task automatic send(input logic [7:0] k);
    wait_ready(200);
    tc.key_valid = 1'b1;
    tc.key_ascii = k;
    tick();
    tc.key_valid = 1'b0;
  endtask

  task automatic do_reset();
    tc.key_valid = 1'b0;
    tc.key_ascii = 8'h00;
    reset = 1'b1;
    tick();
    reset = 1'b0;
  endtask

  task automatic fresh();
    do_reset();
    wait_ready(CELLS + 100);
    m_reset();
  endtask

  typedef struct {
    logic [7:0] key;
    logic       exp_wr;
    int         exp_addr;
    logic [7:0] exp_data;
    int         exp_cur;
  } vec_t;

  vec_t vecs [$];

  initial begin
    int   bad, n_wr, first_wr, cyc_i;
    logic prev_wr, rose_ok;
    logic [7:0] k;
    int   r;

    for (int a = 0; a < CELLS; a++) shadow[a] = 8'h00;
    m_reset();

    // Directed vectors applied from a freshly initialised screen
    vecs.push_back('{8'h08, 1'b0, 0, 8'h20, 0});
    vecs.push_back('{8'h78, 1'b1, 0, 8'h78, 1});
    vecs.push_back('{8'h08, 1'b1, 0, 8'h20, 0});
    vecs.push_back('{8'h41, 1'b1, 0, 8'h41, 1});
    vecs.push_back('{8'h01, 1'b0, 0, 8'h20, 1});
    vecs.push_back('{8'h08, 1'b1, 0, 8'h20, 0});
    vecs.push_back('{8'h61, 1'b1, 0, 8'h61, 1});
    vecs.push_back('{8'h62, 1'b1, 1, 8'h62, 2});
    vecs.push_back('{8'h63, 1'b1, 2, 8'h63, 3});
    vecs.push_back('{8'h64, 1'b1, 3, 8'h64, 4});
    vecs.push_back('{8'h65, 1'b1, 4, 8'h65, 5});
    vecs.push_back('{8'h0D, 1'b0, 0, 8'h20, 70});
    vecs.push_back('{8'h08, 1'b0, 0, 8'h20, 5});
    vecs.push_back('{8'h7F, 1'b0, 0, 8'h20, 5});
    vecs.push_back('{8'h7E, 1'b1, 5, 8'h7E, 6});
    vecs.push_back('{8'h0D, 1'b0, 0, 8'h20, 70});
    vecs.push_back('{8'h08, 1'b0, 0, 8'h20, 6});
    vecs.push_back('{8'h08, 1'b1, 5, 8'h20, 5});
    vecs.push_back('{8'h1F, 1'b0, 0, 8'h20, 5});

    // Reset values and the power-up clear sweep
    tc.key_valid = 1'b0;
    tc.key_ascii = 8'h00;
    reset = 1'b1;
    tick();
    tick();
    check("rst_wr_en", tc.wr_en, 0);
    check("rst_wr_addr", tc.wr_addr, 0);
    check("rst_wr_data", tc.wr_data, 8'h20);
    check("rst_cursor", tc.cursor_addr, 0);
    check("rst_top_row", tc.top_row, 0);
    check("rst_key_ready", tc.key_ready, 0);
    check("rst_busy", tc.busy, 1);
    reset = 1'b0;

    bad = 0; n_wr = 0; first_wr = -1; prev_wr = 1'b0; rose_ok = 1'b0;
    for (int cyc = 0; cyc < CELLS + 50; cyc++) begin
      tick();
      if (tc.wr_en === 1'b1) begin
        if (first_wr < 0) first_wr = cyc;
        if (int'(tc.wr_addr) != n_wr || tc.wr_data !== 8'h20) bad++;
        if (tc.key_ready !== 1'b0 || tc.busy !== 1'b1) bad++;
        n_wr++;
      end else if (tc.key_ready === 1'b1) begin
        rose_ok = prev_wr;
        break;
      end else if (n_wr > 0) begin
        bad++;
      end
      prev_wr = tc.wr_en;
    end
    check("init_first_write_cycle", first_wr, 0);
    check("init_write_count", n_wr, CELLS);
    check("init_write_content", bad, 0);
    check("init_ready_after_last", rose_ok, 1);
    check("init_busy_low", tc.busy, 0);
    check_ram("init_ram");

    // First key after init
    send(8'h41);
    check("A_wr_en", tc.wr_en, 1);
    check("A_wr_addr", tc.wr_addr, 0);
    check("A_wr_data", tc.wr_data, 8'h41);
    check("A_cursor", tc.cursor_addr, 1);
    tick();
    check("A_single_write", tc.wr_en, 0);

    // Vector table
    fresh();
    for (int i = 0; i < vecs.size(); i++) begin
      send(vecs[i].key);
      m_key(vecs[i].key);
      check($sformatf("vec%0d_wr_en", i), tc.wr_en, vecs[i].exp_wr);
      check($sformatf("vec%0d_cursor", i), tc.cursor_addr, vecs[i].exp_cur);
      check($sformatf("vec%0d_ready", i), tc.key_ready, 1);
      check($sformatf("vec%0d_top_row", i), tc.top_row, 0);
      if (vecs[i].exp_wr) begin
        check($sformatf("vec%0d_wr_addr", i), tc.wr_addr, vecs[i].exp_addr);
        check($sformatf("vec%0d_wr_data", i), tc.wr_data, vecs[i].exp_data);
      end
    end
    tick();
    check_ram("vec_ram");

    // Full line typed back-to-back wraps, then backspace across the wrap
    fresh();
    bad = 0;
    for (int i = 0; i < COLS; i++) begin
      k = 8'h41 + 8'(i % 26);
      send(k);
      m_key(k);
      if (tc.wr_en !== 1'b1 || int'(tc.wr_addr) != i || tc.wr_data !== k || tc.key_ready !== 1'b1) bad++;
    end
    check("line70_writes", bad, 0);
    check("line70_cursor", tc.cursor_addr, 70);
    send(8'h08);
    check("wrapbs_wr_en", tc.wr_en, 1);
    check("wrapbs_wr_addr", tc.wr_addr, 69);
    check("wrapbs_wr_data", tc.wr_data, 8'h20);
    check("wrapbs_cursor", tc.cursor_addr, 69);
    send(8'h08);
    check("wrapbs2_wr_addr", tc.wr_addr, 68);
    check("wrapbs2_cursor", tc.cursor_addr, 68);

    // Scroll: clear sweep and a key held off until ready
    fresh();
    for (int i = 0; i < ROWS - 1; i++) send(8'h0D);
    check("enter29_cursor", tc.cursor_addr, (ROWS - 1) * COLS);
    check("enter29_top_row", tc.top_row, 0);
    send(8'h0D);
    check("scroll_top_row", tc.top_row, 1);
    check("scroll_cursor", tc.cursor_addr, 0);
    check("scroll_ready_low", tc.key_ready, 0);
    check("scroll_no_write", tc.wr_en, 0);
    tc.key_valid = 1'b1;
    tc.key_ascii = 8'h5A;
    bad = 0;
    for (int c = 0; c < COLS; c++) begin
      tick();
      if (tc.wr_en !== 1'b1 || int'(tc.wr_addr) != c || tc.wr_data !== 8'h20 || tc.key_ready !== 1'b0) bad++;
    end
    check("clear_writes", bad, 0);
    tick();
    check("clear_done_ready", tc.key_ready, 1);
    check("clear_done_no_write", tc.wr_en, 0);
    tick();
    tc.key_valid = 1'b0;
    check("held_key_wr_en", tc.wr_en, 1);
    check("held_key_wr_addr", tc.wr_addr, 0);
    check("held_key_wr_data", tc.wr_data, 8'h5A);
    check("held_key_cursor", tc.cursor_addr, 1);

    // Reset in the middle of a row clear
    fresh();
    for (int i = 0; i < ROWS; i++) send(8'h0D);
    for (int i = 0; i < 10; i++) tick();
    do_reset();
    check("midclr_wr_en", tc.wr_en, 0);
    check("midclr_busy", tc.busy, 1);
    check("midclr_cursor", tc.cursor_addr, 0);
    check("midclr_top_row", tc.top_row, 0);
    tick();
    check("midclr_init_wr_en", tc.wr_en, 1);
    check("midclr_init_addr", tc.wr_addr, 0);
    wait_ready(CELLS + 100);
    m_reset();
    tick();
    check_ram("midclr_ram");

    // Random key stream against the screen model
    fresh();
    cyc_i = 0;
    for (int i = 0; i < 800; i++) begin
      r = $urandom_range(0, 99);
      if (r < 45)      k = 8'($urandom_range(32, 126));
      else if (r < 70) k = 8'h0D;
      else if (r < 90) k = 8'h08;
      else             k = 8'($urandom_range(0, 255));
      send(k);
      m_key(k);
      tick();
      wait_ready(COLS + 20);
      check($sformatf("rnd%0d_cursor", i), tc.cursor_addr, m_row * COLS + m_col);
      check($sformatf("rnd%0d_top_row", i), tc.top_row, m_top);
      if (i % 8 == 7) check_ram($sformatf("rnd%0d_ram", i));
      if (m_top != 0) cyc_i++;
    end
    check_ram("rnd_final_ram");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end
endmodule

// File: doc/term_cursor_ctrl.md
# term_cursor_ctrl

Write-side controller for the 70×30 character RAM of the VGA text terminal. Consumes decoded keyboard events (ASCII plus a valid strobe), owns the cursor, and sequences every write into the character RAM: character placement, backspace erase, line wrap, hardware scrolling through a top-row offset, and full-screen clear after reset. The VGA read side uses `top_row` to rotate physical rows onto the screen; this block never reads the RAM.

## Interface
Parameters:
- `COLS`, 70, characters per row
- `ROWS`, 30, rows per screen; `COLS*ROWS` ≤ 4096

Ports:
- `clk`  in  1  system clock; all logic on rising edge
- `reset`  in  1  synchronous, active-high; one clock, synchronous reset, active-high
- `key_valid`  in  1  key event strobe; held until accepted
- `key_ascii`  in  8  ASCII code of the event
- `key_ready`  out  1  block can accept an event this cycle
- `wr_en`  out  1  character RAM write enable, one cycle per write
- `wr_addr`  out  12  physical RAM address, `row*COLS+col`
- `wr_data`  out  8  byte to write
- `cursor_addr`  out  12  physical address of the cursor cell
- `top_row`  out  5  physical row shown on the top screen line
- `busy`  out  1  high in INIT or CLEAR

## Operation
- State: `cur_row` (0..ROWS-1), `cur_col` (0..COLS-1), `lines_used` (1..ROWS), `top_row`, `line_len[ROWS]` (7 bits each, 0..COLS), `clr_cnt`.
- FSM states:
  - INIT: writes 0x20 to addresses 0..COLS*ROWS-1, one per cycle. Then IDLE.
  - IDLE: accepts an event on `key_valid && key_ready`.
  - CLEAR: writes 0x20 to the COLS cells of `cur_row`, ascending. Then IDLE.
- Event accepted in IDLE, by code:
  - Printable, 0x20–0x7E: write `key_ascii` at cursor and set `line_len[cur_row] = cur_col+1`.
    - If `cur_col < COLS-1`: `cur_col++`.
    - Else: auto-wrap newline.
  - Enter, 0x0D: `line_len[cur_row] = cur_col`, then newline.
  - Backspace, 0x08:
    - If `cur_col > 0`: `cur_col--` and write 0x20 at the new cursor cell.
    - Else, if `lines_used > 1`: `cur_row--` mod ROWS, `lines_used--`; with L = `line_len` of the new row:
      - L < COLS: `cur_col = L`, no write.
      - L == COLS: `cur_col = COLS-1`, write 0x20 there.
    - Else (top screen line, col 0): ignored, no write.
  - All other codes: ignored. The event is still consumed, with no state change.
- Newline: `cur_col = 0`, `cur_row++` mod ROWS, and the new row's `line_len` is cleared to 0.
  - If `lines_used < ROWS`: `lines_used++`, return to IDLE.
  - Else (scroll): `top_row++` mod ROWS, then enter CLEAR on the new `cur_row`.
- `cursor_addr = cur_row*COLS + cur_col`, registered. It is always in 0..COLS*ROWS-1.

## Timing
- Reset values:
  - `cur_row = cur_col = 0`, `top_row = 0`, `lines_used = 1`, all `line_len = 0`.
  - `wr_en = 0`, `wr_addr = 0`, `wr_data = 0x20`, `cursor_addr = 0`.
  - `key_ready = 0`, `busy = 1`; state INIT.
- INIT: `wr_en` is high for exactly COLS*ROWS consecutive cycles, starting the cycle after reset deasserts.
- `key_ready = (state==IDLE)`, combinational from state. `busy = !key_ready`.
- Write outputs are registered: an event accepted at edge N drives its `wr_*` during cycle N+1. `cursor_addr` updates at edge N.
- Events that cause no scroll leave the FSM in IDLE, so back-to-back acceptance is allowed, one event per cycle.
- A scroll leaves IDLE at edge N:
  - The printable write, if any, occurs in cycle N+1.
  - CLEAR writes occupy the next COLS cycles.
  - `key_ready` returns high after the last clear write.
- `key_valid` while not ready: the event is held off and not dropped. The upstream source must hold `key_valid` and `key_ascii` stable until accepted.
- `reset` asserted in any state, including mid-CLEAR or mid-INIT: state is discarded and INIT restarts from address 0 on the next cycle.
- No two writes are ever issued in the same cycle. Each CLEAR write follows the prior character write.

## Test plan
- Reset, then idle: `wr_en` high for exactly 2100 cycles, with addresses 0..2099 and data 0x20. `key_ready` rises on the cycle after the last write.
- Send `'A'` (0x41) after INIT: one write, addr 0, data 0x41. `cursor_addr = 1`.
- Send 70 printable chars back-to-back:
  - 70 writes to addr 0..69.
  - `cursor_addr = 70` and `lines_used = 2`.
  - `key_ready` never drops.
- From a fresh state, send `"abcde"`, then Enter, then Backspace:
  - The Enter sets `cursor_addr = 70`.
  - The Backspace returns `cursor_addr = 5` with no write.
- Backspace at `cursor_addr = 0`: ignored, no `wr_en`, cursor unchanged. Then Backspace after `'x'`: write 0x20 to addr 0, `cursor_addr = 0`.
- Send 30 Enters from a fresh state:
  - `top_row` goes 0→1 and `cursor_addr = 0`.
  - 70 clear writes follow, to addr 0..69 with data 0x20, and `key_ready` is low throughout.
  - A `key_valid` held during the clear is accepted on the first ready cycle.
  - Reset asserted mid-clear restarts INIT at addr 0.
